// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//
// Bridges a cache that moves whole 256-bit lines to a memory port that moves
// 64-bit beats. A fill (read_i) becomes a 4-beat read burst that is assembled
// into line_o. A writeback (write_i) becomes a 4-beat write burst sliced out
// of line_i. Beat k always carries line[64k+63:64k].
//
// Handshake: read_o / write_o stay high for the whole burst. Each cycle in
// which resp_i is 1 completes exactly one beat: the beat is captured from
// burst_i on a read, or burst_o is consumed on a write. Cycles with resp_i=0
// are gaps and change nothing. resp_o pulses once per finished request.
//
// Optional build macro: CACHELINE_ADAPTOR_FWD_EN
//   When defined, a read finishes in the cycle of its 4th beat: resp_o is
//   raised combinationally and line_o forwards burst_i into its top 64 bits
//   in that cycle, and the FSM returns straight to IDLE (no DONE cycle).
//   Writes are timed the same in both builds.
//
// Ports
//   clk        in   1    sole clock, rising edge
//   reset_n    in   1    synchronous, active-low reset
//   line_i     in   256  writeback line from the cache
//   line_o     out  256  assembled fill line to the cache
//   address_i  in   32   cache line address
//   read_i     in   1    cache fill request
//   write_i    in   1    cache writeback request (wins over read_i)
//   resp_o     out  1    one-cycle completion pulse to the cache
//   burst_i    in   64   read beat from memory
//   burst_o    out  64   write beat to memory
//   address_o  out  32   line-aligned burst address to memory
//   read_o     out  1    read burst request to memory
//   write_o    out  1    write burst request to memory
//   resp_i     in   1    memory beat accept / valid strobe
// -----------------------------------------------------------------------------
module cacheline_adaptor (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [1:0]   beat_cnt;
  logic [1:0]   next_cnt;
  // Holds the latched writeback line during WRITE and the partially
  // assembled fill line during READ; only one burst is ever in flight.
  logic [255:0] buf_q;
  // Last completed fill line; only updated when a read finishes so the
  // cache sees a stable line between fills.
  logic [255:0] line_q;
  logic         resp_q;
  logic         last_beat;

  assign next_cnt  = beat_cnt + 2'd1;
  assign last_beat = resp_i && (beat_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat_cnt  <= 2'd0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_q    <= 1'b0;
      address_o <= 32'd0;
      burst_o   <= 64'd0;
      line_q    <= 256'd0;
      buf_q     <= 256'd0;
    end else begin
      resp_q <= 1'b0;
      case (state)
        IDLE: begin
          beat_cnt <= 2'd0;
          if (write_i) begin
            buf_q     <= line_i;
            // Masking keeps the burst line-aligned.
            address_o <= address_i & 32'hFFFF_FFE0;
            burst_o   <= line_i[63:0];
            write_o   <= 1'b1;
            state     <= WRITE;
          end else if (read_i) begin
            address_o <= address_i & 32'hFFFF_FFE0;
            read_o    <= 1'b1;
            state     <= READ;
          end
        end

        READ: begin
          if (resp_i) begin
            buf_q[{beat_cnt, 6'b0} +: 64] <= burst_i;
            beat_cnt <= next_cnt;
            if (last_beat) begin
              read_o <= 1'b0;
              line_q <= {burst_i, buf_q[191:0]};
`ifdef CACHELINE_ADAPTOR_FWD_EN
              // Completion was already signalled combinationally this cycle.
              state  <= IDLE;
`else
              resp_q <= 1'b1;
              state  <= DONE;
`endif
            end
          end
        end

        WRITE: begin
          if (resp_i) begin
            beat_cnt <= next_cnt;
            if (last_beat) begin
              write_o <= 1'b0;
              resp_q  <= 1'b1;
              state   <= DONE;
            end else begin
              // Present the next slice as soon as the current one is taken.
              burst_o <= buf_q[{next_cnt, 6'b0} +: 64];
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHELINE_ADAPTOR_FWD_EN
  logic fwd_hit;
  assign fwd_hit = (state == READ) && last_beat;
  assign resp_o  = resp_q | fwd_hit;
  assign line_o  = fwd_hit ? {burst_i, buf_q[191:0]} : line_q;
`else
  assign resp_o  = resp_q;
  assign line_o  = line_q;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//
// Directed and randomized bursts against cacheline_adaptor. The reference is
// a beat-level view of the line: expected write beats are queued slices of
// the written line, the expected fill line is the concatenation of the beats
// handed to the adaptor, and completion timing is derived from where the 4th
// accepted beat falls in the resp_i pattern.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

  logic         clk;
  logic         reset_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_adaptor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int           checks;
  int           failures;
  int           lat_add;
  logic [255:0] last_line;
  logic [63:0]  exp_q[$];
  logic [1:0]   dut_state;

  assign dut_state = 2'(dut.state);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk(tag, {255'b0, obs}, {255'b0, exp});
  endtask

  function automatic logic [63:0] junk64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic logic [255:0] junk256();
    return {junk64(), junk64(), junk64(), junk64()};
  endfunction

  // Cycle (counted from the request cycle) in which the 4th beat is offered.
  // Beats are offered from cycle 2 on; pattern bit i gates cycle 2+i, and
  // once the pattern is exhausted every cycle carries a beat.
  function automatic int beat4_cycle(input logic [15:0] pat);
    int ones;
    ones = 0;
    for (int c = 2; c < 30; c++) begin
      if ((c - 2 >= 16) ? 1'b1 : pat[c - 2]) ones++;
      if (ones == 4) return c;
    end
    return -1;
  endfunction

  // ---------------- driver: fill ----------------
  task automatic run_read(input logic [31:0] addr, input logic [255:0] line_exp,
                          input logic [15:0] pat, input string tag, output int done_o);
    int          cyc, nb, pi, done, exp_done;
    bit          give;
    logic [31:0] exp_addr;
    logic [255:0] exp_line;
    exp_addr = {addr[31:5], 5'b0};
    exp_done = beat4_cycle(pat) + lat_add;
    cyc = 0; nb = 0; pi = 0; done = -1;

    @(negedge clk);
    read_i = 1'b1; write_i = 1'b0; address_i = addr;
    resp_i = 1'b0; burst_i = junk64(); line_i = junk256();
    #1;
    chk_b({tag, "_resp_req"}, resp_o, 1'b0);

    while ((done < 0 || cyc <= done) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      read_i    = (nb < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      write_i   = (nb < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      address_i = $urandom();
      give = 1'b0;
      if (cyc >= 2 && nb < 4) begin
        give = (pi >= 16) ? 1'b1 : pat[pi];
        pi++;
      end
      resp_i  = give ? 1'b1 : ((nb == 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      burst_i = give ? line_exp[64*nb +: 64] : junk64();
      #1;
      if (give && nb == 3) done = cyc + lat_add;
      exp_line = (done >= 0 && cyc >= done) ? line_exp : last_line;
      chk_b({tag, "_read_o"}, read_o, nb < 4);
      chk_b({tag, "_write_o"}, write_o, 1'b0);
      chk({tag, "_address_o"}, 256'(address_o), 256'(exp_addr));
      chk_b({tag, "_resp_o"}, resp_o, cyc == done);
      chk({tag, "_line_o"}, line_o, exp_line);
      if (give) nb++;
    end
    chk_b({tag, "_completed"}, done >= 0, 1'b1);
    chk({tag, "_latency"}, 256'(done), 256'(exp_done));
    last_line = line_exp;
    done_o = done;
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
  endtask

  // ---------------- driver: writeback ----------------
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic also_read, input logic [15:0] pat, input string tag);
    int          cyc, nb, pi, done, exp_done;
    bit          give;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    exp_done = beat4_cycle(pat) + 1;
    cyc = 0; nb = 0; pi = 0; done = -1;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(line[64*k +: 64]);

    @(negedge clk);
    write_i = 1'b1; read_i = also_read; address_i = addr; line_i = line;
    resp_i = 1'b0; burst_i = junk64();
    #1;

    while ((done < 0 || cyc <= done) && cyc < 40) begin
      @(negedge clk);
      cyc++;
      read_i    = (nb < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      write_i   = (nb < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      address_i = $urandom();
      line_i    = junk256();
      give = 1'b0;
      if (cyc >= 2 && nb < 4) begin
        give = (pi >= 16) ? 1'b1 : pat[pi];
        pi++;
      end
      resp_i  = give ? 1'b1 : ((nb == 4) ? 1'($urandom_range(0, 1)) : 1'b0);
      burst_i = junk64();
      #1;
      chk_b({tag, "_write_o"}, write_o, nb < 4);
      chk_b({tag, "_read_o"}, read_o, 1'b0);
      chk({tag, "_address_o"}, 256'(address_o), 256'(exp_addr));
      chk_b({tag, "_resp_o"}, resp_o, cyc == done);
      chk({tag, "_line_o_hold"}, line_o, last_line);
      if (nb < 4) chk({tag, "_burst_o"}, 256'(burst_o), 256'(exp_q[0]));
      if (give) begin
        void'(exp_q.pop_front());
        nb++;
        if (nb == 4) done = cyc + 1;
      end
    end
    chk_b({tag, "_completed"}, done >= 0, 1'b1);
    chk({tag, "_latency"}, 256'(done), 256'(exp_done));
    chk({tag, "_beats_left"}, 256'(exp_q.size()), 256'(0));
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           d;
    logic [255:0] ln;
    checks = 0; failures = 0; last_line = 256'd0;
`ifdef CACHELINE_ADAPTOR_FWD_EN
    lat_add = 0;
`else
    lat_add = 1;
`endif
    reset_n = 1'b0; read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
    line_i = junk256(); address_i = $urandom(); burst_i = junk64();

    // Reset state, with requests and beats pending on the inputs.
    repeat (3) @(negedge clk);
    #1;
    chk_b("rst_read_o", read_o, 1'b0);
    chk_b("rst_write_o", write_o, 1'b0);
    chk_b("rst_resp_o", resp_o, 1'b0);
    chk("rst_address_o", 256'(address_o), 256'(0));
    chk("rst_burst_o", 256'(burst_o), 256'(0));
    chk("rst_line_o", line_o, 256'd0);
    chk("rst_state", 256'(dut_state), 256'(0));
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0; reset_n = 1'b1;

    // Basic fill, back-to-back beats: completion in cycle 6 (5 forwarded).
    run_read(32'h0000_1234,
             {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}},
             16'hFFFF, "rd_basic", d);
    chk("rd_basic_cycle", 256'(d), 256'(5 + lat_add));
    chk("rd_basic_addr", 256'(address_o), 256'(32'h0000_1220));

    // Writeback of a random line, back-to-back beats.
    run_write($urandom(), junk256(), 1'b0, 16'hFFFF, "wr_basic");

    // Gapped fill: resp_i = 1,0,0,1,1,0,1.
    run_read($urandom(), junk256(), 16'h0059, "rd_gap", d);

    // Simultaneous read and write request: write wins.
    run_write($urandom(), junk256(), 1'b1, 16'hFFFF, "wr_both");

    // Random mix of fills and writebacks with random beat gaps.
    for (int t = 0; t < 8; t++) begin
      if ($urandom_range(0, 1) == 1)
        run_write($urandom(), junk256(), 1'($urandom_range(0, 1)), 16'($urandom()), "rnd_wr");
      else
        run_read($urandom(), junk256(), 16'($urandom()), "rnd_rd", d);
    end

    // Reset in the middle of a fill, after two beats.
    @(negedge clk);
    read_i = 1'b1; address_i = $urandom(); resp_i = 1'b0;
    @(negedge clk);
    read_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = junk64();
    end
    @(negedge clk);
    reset_n = 1'b0; resp_i = 1'b1; burst_i = junk64();
    @(negedge clk);
    reset_n = 1'b1; resp_i = 1'b1; burst_i = junk64();
    #1;
    chk_b("mid_rst_read_o", read_o, 1'b0);
    chk_b("mid_rst_resp_o", resp_o, 1'b0);
    chk("mid_rst_state", 256'(dut_state), 256'(0));
    chk("mid_rst_line_o", line_o, 256'd0);
    last_line = 256'd0;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = junk64();
      #1;
      chk_b("post_rst_resp_o", resp_o, 1'b0);
      chk_b("post_rst_read_o", read_o, 1'b0);
      chk("post_rst_line_o", line_o, 256'd0);
    end
    resp_i = 1'b0;

    // Recovery after the aborted burst.
    ln = junk256();
    run_read($urandom(), ln, 16'($urandom()), "rd_recover", d);
    run_write($urandom(), junk256(), 1'b0, 16'($urandom()), "wr_recover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
